// File: rtl/rm_monitor_sequencer_if.sv
// Symbol stream and automata-cluster bus bundle for rm_monitor_sequencer.
interface rm_monitor_sequencer_if #(
  parameter int unsigned NUM_REPORTS = 4
);
  logic                   in_valid;
  logic [7:0]             in_symbol;
  logic                   in_ready;
  logic                   auto_reset;
  logic                   auto_run;
  logic [7:0]             auto_symbols;
  logic [NUM_REPORTS-1:0] auto_report;

  // Trace source and cluster side (drives symbols in, returns reports)
  modport master (
    output in_valid, in_symbol, auto_report,
    input  in_ready, auto_reset, auto_run, auto_symbols
  );

  // Sequencer side
  modport slave (
    input  in_valid, in_symbol, auto_report,
    output in_ready, auto_reset, auto_run, auto_symbols
  );
endinterface

// File: rtl/rm_monitor_sequencer.sv
// Buffers trace symbols, sequences the automata cluster start-of-data reset,
// issues one symbol per cycle and halts on the first masked report.
module rm_monitor_sequencer #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned NUM_REPORTS = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned RST_CYCLES  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_enable,
  input  logic                   cfg_restart,
  input  logic [NUM_REPORTS-1:0] cfg_report_mask,
  rm_monitor_sequencer_if.slave  bus,
  output logic                   viol_valid,
  output logic [NUM_REPORTS-1:0] viol_id,
  output logic [CNT_W-1:0]       viol_index,
  output logic [CNT_W-1:0]       sym_count,
  output logic                   busy
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_HALT} state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          init_cnt;
  logic [7:0]             mem [DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic                   full, empty, ready;
  logic                   restart, push, pop, init_start, viol_hit;
  logic [NUM_REPORTS-1:0] masked;
  logic                   issue_vld, eval_vld;
  logic [CNT_W-1:0]       issue_idx, eval_idx;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign ready   = !full && (state != S_IDLE);
  assign bus.in_ready = ready;

  assign restart = cfg_restart && (state != S_IDLE);
  assign push    = bus.in_valid && ready && !restart;
  assign pop     = (state == S_RUN) && cfg_enable && !empty && !restart;
  assign masked  = bus.auto_report & cfg_report_mask;
  // The report arriving now belongs to the symbol issued two edges ago
  assign viol_hit = (state == S_RUN) && eval_vld && !viol_valid && (masked != '0) && !restart;
  assign init_start = restart || (state == S_IDLE);

  // Next-state selection; restart outranks a violation in the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_INIT;
      S_INIT: begin
        if (restart)                              state_nxt = S_INIT;
        else if (init_cnt == IW'(RST_CYCLES - 1)) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (restart)       state_nxt = S_INIT;
        else if (viol_hit) state_nxt = S_HALT;
      end
      S_HALT: begin
        if (restart) state_nxt = S_INIT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register and INIT dwell counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (init_start)
        init_cnt <= '0;
      else if (state == S_INIT)
        init_cnt <= init_cnt + IW'(1);
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.in_symbol;
  end

  // FIFO pointers and occupancy; restart flushes
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Cluster drive, issue/evaluate pipeline and violation status
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.auto_reset   <= 1'b1;
      bus.auto_run     <= 1'b0;
      bus.auto_symbols <= '0;
      busy             <= 1'b0;
      issue_vld        <= 1'b0;
      issue_idx        <= '0;
      eval_vld         <= 1'b0;
      eval_idx         <= '0;
      sym_count        <= '0;
      viol_valid       <= 1'b0;
      viol_id          <= '0;
      viol_index       <= '0;
    end else begin
      bus.auto_reset <= (state_nxt == S_IDLE) || (state_nxt == S_INIT);
      busy           <= (state_nxt == S_INIT) || (state_nxt == S_RUN);
      bus.auto_run   <= pop;
      if (pop)
        bus.auto_symbols <= mem[rd_ptr];
      if (init_start) begin
        issue_vld  <= 1'b0;
        eval_vld   <= 1'b0;
        sym_count  <= '0;
        viol_valid <= 1'b0;
        viol_id    <= '0;
        viol_index <= '0;
      end else begin
        issue_vld <= pop;
        eval_vld  <= issue_vld;
        eval_idx  <= issue_idx;
        if (pop) begin
          issue_idx <= sym_count;
          if (sym_count != '1)
            sym_count <= sym_count + CNT_W'(1);
        end
        if (viol_hit) begin
          viol_valid <= 1'b1;
          viol_id    <= masked;
          viol_index <= eval_idx;
        end
      end
    end
  end
endmodule

// File: doc/rm_monitor_sequencer.md
Name: rm_monitor_sequencer

Overview:
- Feeds an 8-bit runtime-monitor symbol stream into one automata cluster.
- The cluster is a set of STE-based LTL monitors driven by run/reset/symbols; it returns a vector of report (accepting-state) bits.
- The block buffers incoming trace symbols, runs the cluster start-of-data reset sequence, and issues at most one symbol per cycle.
- It samples the cluster reports one cycle after each issue, latches the first masked report as a violation, and halts.

Parameters:
- DEPTH, 8, symbol FIFO entries (power of 2, >=2)
- NUM_REPORTS, 4, width of the cluster report vector
- CNT_W, 32, width of the symbol index counter
- RST_CYCLES, 2, cycles auto_reset is held high in INIT (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_enable  in  1  allow issuing symbols in RUN
- cfg_restart  in  1  one-cycle pulse: flush, re-initialise the cluster, clear status
- cfg_report_mask  in  NUM_REPORTS  1 = report bit counts as a violation
- in_valid  in  1  symbol offered
- in_symbol  in  8  trace symbol
- in_ready  out  1  FIFO can accept a symbol
- auto_reset  out  1  reset to the automata cluster
- auto_run  out  1  run strobe to the cluster
- auto_symbols  out  8  symbol to the cluster
- auto_report  in  NUM_REPORTS  cluster report outputs (registered inside the cluster)
- viol_valid  out  1  sticky violation flag
- viol_id  out  NUM_REPORTS  masked report bits at the violation
- viol_index  out  CNT_W  0-based index of the offending symbol
- sym_count  out  CNT_W  symbols issued since the last init
- busy  out  1  FSM is not IDLE and not HALT

Behaviour:
- Reset values:
  - FSM = IDLE; FIFO empty.
  - in_ready=0; auto_reset=1; auto_run=0; auto_symbols=0.
  - viol_valid=0; viol_id=0; viol_index=0; sym_count=0; busy=0.
- All outputs are registered except in_ready.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready = !full && state != IDLE. No bypass.
  - A simultaneous push and pop is allowed when not full.
  - Pointers wrap modulo DEPTH.
  - Full/empty are derived from an occupancy counter of width clog2(DEPTH)+1.
- FSM states:
  - IDLE: auto_reset=1. Goes to INIT on the first cycle after reset deasserts.
  - INIT: auto_reset=1, auto_run=0 for RST_CYCLES cycles, which covers both clock edges of the cluster start_of_data logic. Then auto_reset=0 and go to RUN. sym_count, viol_* and the pipeline valid bit are cleared on entry.
  - RUN: if cfg_enable && FIFO not empty, pop the head symbol. In that same cycle, register auto_symbols <= head and auto_run <= 1, and set issue_vld <= 1 and issue_idx <= sym_count. Then sym_count increments, saturating at all-ones. Otherwise auto_run <= 0 and auto_symbols holds its value.
  - HALT: no pops; auto_run=0; auto_reset=0; the FIFO keeps accepting until full; viol_* hold.
- Report sampling:
  - The cluster updates at the posedge where auto_run=1.
  - So auto_report is sampled in the cycle after auto_run was high, qualified by the delayed issue_vld.
  - If (auto_report & cfg_report_mask) != 0: set viol_valid=1, viol_id = masked bits, viol_index = issue_idx, and go to HALT.
  - The FSM moves to HALT on that same edge. No further symbol is issued after the offending one's evaluation cycle.
  - A symbol already issued in the evaluation cycle may be in flight. Its report is ignored once viol_valid=1; only the first violation is latched.
- cfg_enable low in RUN: issuing stops. The one in-flight symbol is still evaluated and may cause HALT.
- cfg_restart (any state except IDLE):
  - Next state INIT; FIFO flushed.
  - A push in the same cycle is dropped.
  - An in-flight evaluation is discarded.
  - It has priority over a violation detected in the same cycle.
- reset asserted mid-operation: all state returns to reset values on the next edge; the FIFO content is lost.
- An unmasked report bit never halts or alters viol_*.

Test Plan:
- Reset for 3 cycles, then release -> auto_reset=1 for exactly 2 cycles after IDLE; busy=1; in_ready=1; auto_run=0 throughout INIT.
- Push 0x08, 0x10, 0x20 with cfg_enable=1 and mask=4'b0000; the model raises report bit 1 on 0x10 -> three consecutive auto_run pulses carrying those symbols in order; sym_count=3; viol_valid stays 0.
- Same stream with mask=4'b0010 -> viol_valid=1, viol_id=4'b0010, viol_index=1, FSM in HALT; 0x20 is issued at most once and sym_count<=3; no further auto_run.
- Push 9 symbols with cfg_enable=0, DEPTH=8 -> in_ready drops after 8 accepted. Raise cfg_enable -> 8 symbols issued back-to-back in FIFO order; the 9th is accepted once space frees.
- In HALT, pulse cfg_restart while in_valid=1 -> that push is dropped; FIFO empty; viol_valid=0; sym_count=0; auto_reset high for 2 cycles; then RUN.
- Assert reset mid-RUN with 4 symbols buffered -> next cycle all outputs at reset values and the FIFO is empty; no auto_run pulse is emitted.
